// File: rtl/sdcard_port_arbiter.sv
// Multi-port front end for the SD-card cache: picks one requesting port at a time, issues its request
// on the shared cache interface and routes the single response beat back to that port.
module sdcard_port_arbiter #(
  parameter int unsigned ADDR   = 32,
  parameter int unsigned DATA   = 64,
  parameter int unsigned CMD    = 1,
  parameter int unsigned NPORTS = 4,
  parameter int unsigned MODE   = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NPORTS-1:0]      req_valid,
  output logic [NPORTS-1:0]      req_ready,
  input  logic [NPORTS*ADDR-1:0] req_addr,
  input  logic [NPORTS*DATA-1:0] req_data,
  input  logic [NPORTS*CMD-1:0]  req_cmd,
  output logic [NPORTS-1:0]      rsp_valid,
  input  logic [NPORTS-1:0]      rsp_ready,
  output logic [DATA-1:0]        rsp_data,
  output logic                   cpu_valid_in,
  input  logic                   cpu_ready_in,
  output logic [ADDR-1:0]        cpu_addr_in,
  output logic [DATA-1:0]        cpu_data_in,
  output logic [CMD-1:0]         cpu_cmd_in,
  input  logic                   cpu_valid_out,
  output logic                   cpu_ready_out,
  input  logic [DATA-1:0]        cpu_data_out
);

  localparam int unsigned GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [GW-1:0] LastPort = GW'(NPORTS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [DATA-1:0] data_q, data_d;
  logic [CMD-1:0]  cmd_q, cmd_d;
  logic [DATA-1:0] rsp_data_q, rsp_data_d;

  logic            arb_found;
  logic [GW-1:0]   arb_idx;
  logic [GW-1:0]   cand;
  logic [NPORTS-1:0] ready_raw;

  // Arbitration: fixed priority scans upward from port 0; round-robin scans upward from ptr+1.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    if (MODE == 1) begin
      for (int unsigned i = 0; i < NPORTS; i++) begin
        cand = GW'(i);
        if (!arb_found && req_valid[cand]) begin
          arb_found = 1'b1;
          arb_idx   = cand;
        end
      end
    end else begin
      for (int unsigned i = 1; i <= NPORTS; i++) begin
        cand = GW'((32'(ptr_q) + i) % NPORTS);
        if (!arb_found && req_valid[cand]) begin
          arb_found = 1'b1;
          arb_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    addr_d        = addr_q;
    data_d        = data_q;
    cmd_d         = cmd_q;
    rsp_data_d    = rsp_data_q;
    ready_raw     = '0;
    rsp_valid     = '0;
    cpu_valid_in  = 1'b0;
    cpu_ready_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          ready_raw[arb_idx] = 1'b1;
          grant_d            = arb_idx;
          addr_d             = req_addr[32'(arb_idx) * ADDR +: ADDR];
          data_d             = req_data[32'(arb_idx) * DATA +: DATA];
          cmd_d              = req_cmd[32'(arb_idx) * CMD +: CMD];
          state_d            = StIssue;
        end
      end
      StIssue: begin
        cpu_valid_in = 1'b1;
        if (cpu_ready_in) state_d = StWait;
      end
      StWait: begin
        cpu_ready_out = 1'b1;
        if (cpu_valid_out) begin
          rsp_data_d = cpu_data_out;
          state_d    = StResp;
        end
      end
      StResp: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          state_d = StIdle;
          if (MODE == 0) ptr_d = grant_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // req_ready is combinational from req_valid, so it is forced low while reset is held.
  assign req_ready   = reset ? ready_raw : '0;
  assign cpu_addr_in = addr_q;
  assign cpu_data_in = data_q;
  assign cpu_cmd_in  = cmd_q;
  assign rsp_data    = rsp_data_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      ptr_q      <= LastPort;
      addr_q     <= '0;
      data_q     <= '0;
      cmd_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cmd_q      <= cmd_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_sdcard_port_arbiter.sv
// Directed bench for sdcard_port_arbiter: one round-robin instance (index 0) and one
// fixed-priority instance (index 1), driven with hand-computed expectations.
module tb_sdcard_port_arbiter;

  logic         clock;
  logic         reset;
  logic [3:0]   req_valid     [2];
  logic [3:0]   req_ready     [2];
  logic [127:0] req_addr      [2];
  logic [255:0] req_data      [2];
  logic [3:0]   req_cmd       [2];
  logic [3:0]   rsp_valid     [2];
  logic [3:0]   rsp_ready     [2];
  logic [63:0]  rsp_data      [2];
  logic         cpu_valid_in  [2];
  logic         cpu_ready_in  [2];
  logic [31:0]  cpu_addr_in   [2];
  logic [63:0]  cpu_data_in   [2];
  logic [0:0]   cpu_cmd_in    [2];
  logic         cpu_valid_out [2];
  logic         cpu_ready_out [2];
  logic [63:0]  cpu_data_out  [2];

  int total = 0;
  int bad   = 0;

  sdcard_port_arbiter #(.MODE(0)) dut_rr (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_data(req_data[0]), .req_cmd(req_cmd[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .cpu_valid_in(cpu_valid_in[0]),
    .cpu_ready_in(cpu_ready_in[0]), .cpu_addr_in(cpu_addr_in[0]), .cpu_data_in(cpu_data_in[0]),
    .cpu_cmd_in(cpu_cmd_in[0]), .cpu_valid_out(cpu_valid_out[0]),
    .cpu_ready_out(cpu_ready_out[0]), .cpu_data_out(cpu_data_out[0])
  );

  sdcard_port_arbiter #(.MODE(1)) dut_fp (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_data(req_data[1]), .req_cmd(req_cmd[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .cpu_valid_in(cpu_valid_in[1]),
    .cpu_ready_in(cpu_ready_in[1]), .cpu_addr_in(cpu_addr_in[1]), .cpu_data_in(cpu_data_in[1]),
    .cpu_cmd_in(cpu_cmd_in[1]), .cpu_valid_out(cpu_valid_out[1]),
    .cpu_ready_out(cpu_ready_out[1]), .cpu_data_out(cpu_data_out[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // One full transaction from IDLE with minimum latency; g is the port expected to win.
  task automatic txn(input int m, input int g, input logic [63:0] rd, input string tag);
    logic [3:0]  oh;
    logic [31:0] ea;
    logic [63:0] ed;
    logic        ec;
    oh = 4'b0001 << g;
    ea = req_addr[m][g*32 +: 32];
    ed = req_data[m][g*64 +: 64];
    ec = req_cmd[m][g];
    cpu_ready_in[m] = 1'b1;
    #1;
    check({tag, ".req_ready"}, 64'(req_ready[m]), 64'(oh));
    step();
    check({tag, ".cpu_valid_in"}, 64'(cpu_valid_in[m]), 64'd1);
    check({tag, ".cpu_addr_in"}, 64'(cpu_addr_in[m]), 64'(ea));
    check({tag, ".cpu_data_in"}, cpu_data_in[m], ed);
    check({tag, ".cpu_cmd_in"}, 64'(cpu_cmd_in[m]), 64'(ec));
    step();
    check({tag, ".cpu_ready_out"}, 64'(cpu_ready_out[m]), 64'd1);
    cpu_ready_in[m]  = 1'b0;
    cpu_valid_out[m] = 1'b1;
    cpu_data_out[m]  = rd;
    step();
    cpu_valid_out[m] = 1'b0;
    check({tag, ".rsp_valid"}, 64'(rsp_valid[m]), 64'(oh));
    check({tag, ".rsp_data"}, rsp_data[m], rd);
    rsp_ready[m] = 4'hF;
    step();
    rsp_ready[m] = 4'h0;
    check({tag, ".rsp_done"}, 64'(rsp_valid[m]), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      req_valid[m]     = '0;
      req_cmd[m]       = '0;
      rsp_ready[m]     = '0;
      cpu_ready_in[m]  = 1'b0;
      cpu_valid_out[m] = 1'b0;
      cpu_data_out[m]  = '0;
      for (int p = 0; p < 4; p++) begin
        req_addr[m][p*32 +: 32] = 32'(p * 256);
        req_data[m][p*64 +: 64] = 64'(p) * 64'h1111_1111_1111_1111;
      end
    end

    // Reset state
    step();
    check("rst.req_ready", 64'(req_ready[0]), 64'd0);
    check("rst.cpu_valid_in", 64'(cpu_valid_in[0]), 64'd0);
    check("rst.cpu_addr_in", 64'(cpu_addr_in[0]), 64'd0);
    check("rst.rsp_data", rsp_data[0], 64'd0);
    check("rst.fp_cpu_ready_out", 64'(cpu_ready_out[1]), 64'd0);
    step();
    reset = 1'b1;
    step();

    // Test 1: port 2 read at 0x200
    req_valid[0] = 4'b0100;
    txn(0, 2, 64'hDEAD_BEEF_0123_4567, "t1");
    req_valid[0] = 4'b0000;

    // Test 5: reset while waiting on the cache; pointer was 2 so port 3 wins
    req_valid[0] = 4'b1000;
    cpu_ready_in[0] = 1'b1;
    #1;
    check("t5.req_ready", 64'(req_ready[0]), 64'b1000);
    step();
    step();
    check("t5.in_wait", 64'(cpu_ready_out[0]), 64'd1);
    reset = 1'b0;
    #1;
    check("t5.rst_cpu_ready_out", 64'(cpu_ready_out[0]), 64'd0);
    check("t5.rst_cpu_valid_in", 64'(cpu_valid_in[0]), 64'd0);
    check("t5.rst_req_ready", 64'(req_ready[0]), 64'd0);
    check("t5.rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("t5.rst_cpu_addr_in", 64'(cpu_addr_in[0]), 64'd0);
    check("t5.rst_rsp_data", rsp_data[0], 64'd0);
    cpu_ready_in[0] = 1'b0;
    req_valid[0] = 4'b0101;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("t5.no_stale_rsp", 64'(rsp_valid[0]), 64'd0);
    txn(0, 0, 64'h0000_0000_0000_0A0A, "t5.p0");
    txn(0, 2, 64'h0000_0000_0000_0B0B, "t5.p2");
    req_valid[0] = 4'b0000;

    // Test 4: cache stalls request 5 cycles, port stalls response 3 cycles
    req_valid[0] = 4'b0010;
    cpu_ready_in[0] = 1'b0;
    #1;
    check("t4.req_ready", 64'(req_ready[0]), 64'b0010);
    step();
    req_valid[0] = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4.stall_valid", 64'(cpu_valid_in[0]), 64'd1);
      check("t4.stall_addr", 64'(cpu_addr_in[0]), 64'h100);
      check("t4.stall_data", cpu_data_in[0], 64'h1111_1111_1111_1111);
      check("t4.busy_req_ready", 64'(req_ready[0]), 64'd0);
      check("t4.no_early_rsp_accept", 64'(cpu_ready_out[0]), 64'd0);
      step();
    end
    cpu_ready_in[0] = 1'b1;
    step();
    cpu_ready_in[0]  = 1'b0;
    cpu_valid_out[0] = 1'b1;
    cpu_data_out[0]  = 64'h0123_4567_89AB_CDEF;
    step();
    cpu_valid_out[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t4.hold_rsp_valid", 64'(rsp_valid[0]), 64'b0010);
      check("t4.hold_rsp_data", rsp_data[0], 64'h0123_4567_89AB_CDEF);
      step();
    end
    rsp_ready[0] = 4'hF;
    step();
    rsp_ready[0] = 4'h0;
    check("t4.rsp_done", 64'(rsp_valid[0]), 64'd0);
    check("t4.next_rr", 64'(req_ready[0]), 64'b0100);
    req_valid[0] = 4'b0000;
    step();

    // Test 2: all ports valid, pointer at 1 -> 2,3,0,1,2,3,0,1
    req_valid[0] = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      txn(0, (i + 2) % 4, 64'(i + 100), "t2");
    end
    req_valid[0] = 4'b0000;

    // Test 6: port 0 write
    req_addr[0][31:0] = 32'h0000_1000;
    req_data[0][63:0] = 64'hA5A5_A5A5_A5A5_A5A5;
    req_cmd[0][0]     = 1'b1;
    req_valid[0]      = 4'b0001;
    txn(0, 0, 64'h0, "t6");
    req_valid[0] = 4'b0000;
    check("t6.cmd_held", 64'(cpu_cmd_in[0]), 64'd1);
    check("t6.data_held", cpu_data_in[0], 64'hA5A5_A5A5_A5A5_A5A5);
    step();
    check("t6.single_beat", 64'(rsp_valid[0]), 64'd0);

    // Test 3: fixed priority, ports 1 and 3 valid
    req_valid[1] = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      txn(1, 1, 64'(i + 7), "t3.p1");
    end
    req_valid[1] = 4'b1000;
    txn(1, 3, 64'h33, "t3.p3");
    req_valid[1] = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
